axis_tx_packer: RTL
===================

Name: axis_tx_packer

Overview:
- Transmit end of the compressed-output interface: consumes the 15-bit compressed words (data / valid / stop / end) from the image compression top.
- Packs two words per 32-bit AXI4-Stream master beat and buffers beats in a small FIFO.
- Marks the final beat with tlast; back-pressures the compressor through its stop input.
- Sits between the compression top and the DMA/stream interconnect toward the PS.

Parameters:
- DATA_W, 15, compressed word width (must be ≤ 15; each word occupies one 16-bit lane, zero-extended).
- FIFO_DEPTH, 4, beat FIFO entries (power of 2).
- FIFO_AW, 2, log2(FIFO_DEPTH).
- CNT_W, 16, width of word/beat status counters.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a new frame; honoured in IDLE or DONE only.
- c_data  input  DATA_W  compressed word from compressor (odata).
- c_valid  input  1  c_data valid (o_valid).
- c_end  input  1  compressor finished (end_flag); level, stays high.
- c_stop  output  1  stall to compressor (drives out_stop).
- m_axis_tdata  output  32  packed beat.
- m_axis_tkeep  output  4  byte enables.
- m_axis_tlast  output  1  final beat of frame.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- words_cnt  output  CNT_W  words accepted this frame.
- beats_cnt  output  CNT_W  beats handed off this frame.
- done  output  1  frame fully transmitted; held until next start.
- now_state  output  2  current FSM state.

Behaviour:
- Reset (rst=0, any time, including mid-frame): state IDLE, FIFO empty, pack register empty.
  - All outputs 0: c_stop=0, tvalid=0, tdata=0, tkeep=0, tlast=0, counters=0, done=0.
- FSM states:
  - IDLE(0) → RUN on start.
  - RUN(1) → FLUSH on c_end=1.
  - FLUSH(2): one push of the pack register if needed, then → DRAIN.
  - DRAIN(3) → DONE when FIFO empty.
  - DONE: encoded as IDLE with done=1. start in DONE clears counters and done, → RUN.
  - start in RUN/FLUSH/DRAIN is ignored.
- Word accept: on a clk edge with state RUN, c_valid=1 and c_stop=0. The compressor holds data while c_stop=1, so a held word is accepted exactly once. words_cnt increments per accept, saturating at all-ones.
- Pack register holds 0, 1 or 2 words (pack_cnt).
  - First word → lane0: tdata[15:0] = {0, word}.
  - Second word → lane1: tdata[31:16].
  - A full pack is pushed only when a third word arrives, as {tkeep=1111, tlast=0}; the new word becomes lane0 of a fresh pack, all in one edge. This one-pack lookahead guarantees tlast can land on the true final beat.
- c_stop = (state==RUN && pack_cnt==2 && fifo_full) || state==FLUSH || state==DRAIN. Combinational from registered state only; no path from c_valid.
- c_end and c_valid high together in RUN: accept the word, then move to FLUSH; the word is included in the flush.
- FLUSH:
  - pack_cnt==2 → push {tkeep=1111, tlast=1}.
  - pack_cnt==1 → push {lane1=0, tkeep=0011, tlast=1}.
  - pack_cnt==0 → no push. If words_cnt==0 the frame has zero beats and done is still asserted.
  - If the FIFO is full, stay in FLUSH until a slot frees.
- FIFO:
  - Show-ahead: tdata/tkeep/tlast/tvalid come from registered head entry; tvalid = !fifo_empty.
  - Pop on tvalid&&tready; beats_cnt increments per pop.
  - Push and pop in the same cycle are allowed when full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
  - AXI rule: once tvalid=1, tdata/tkeep/tlast remain stable until the handshake.
- done rises on the edge the FIFO becomes empty in DRAIN. Latency from final accepted word to its beat's tvalid is 2 clk with no stall (accept → FLUSH push → head visible).
- Inputs in IDLE/DONE are ignored; c_stop=0 there.

Decomposition:
- Shared package: FSM state encodings, TKEEP_FULL=4'b1111, TKEEP_HALF=4'b0011, lane width 16.
- One sub-module: axis_beat_fifo (parameterised width 37 = 32+4+1, FIFO_DEPTH; push/pop/full/empty, show-ahead read).
- FSM, pack register and counters live in axis_tx_packer.

Test Plan:
- 4 words 0x0001..0x0004, tready=1 → beats 0x00020001 (tlast=0), 0x00040003 (tkeep=1111, tlast=1); beats_cnt=2, done=1.
- 3 words 0x7FFF,0x1234,0x0ABC, tready=1 → 0x12347FFF (tlast=0), then 0x00000ABC with tkeep=0011, tlast=1.
- tready=0, 12 words streamed → c_stop=1 once 4 beats are queued and the pack is full.
  - Compressor holds; no word lost or duplicated.
  - Release tready → 6 beats in order, words_cnt=12.
- start then c_end with no c_valid → no tvalid ever; done=1, beats_cnt=0.
- c_valid=1 with c_end=1 on the 5th word → last beat {0, w5} with tkeep=0011, tlast=1.
- rst low mid-frame with 2 beats queued → all outputs 0 next cycle; a new start frame of 2 words yields a single beat with tlast=1.

Source files
------------

// File: rtl/axis_tx_packer_pkg.sv
// Shared definitions for the compressed-output AXI4-Stream transmitter.
//   state_e    : packer FSM encoding (DONE is StIdle with done=1)
//   TKEEP_*    : byte-enable patterns for full and half beats
//   LANE_W     : width of one 16-bit word lane inside a 32-bit beat
//   BEAT_W     : FIFO entry width {tlast, tkeep, tdata}
//   pack_beat  : assembles a FIFO entry from two lanes and sideband bits
package axis_tx_packer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [3:0]  TKEEP_FULL = 4'b1111;
  localparam logic [3:0]  TKEEP_HALF = 4'b0011;
  localparam int unsigned LANE_W     = 16;
  localparam int unsigned BEAT_W     = 2 * LANE_W + 4 + 1;

  function automatic logic [BEAT_W-1:0] pack_beat(input logic [LANE_W-1:0] hi,
                                                  input logic [LANE_W-1:0] lo,
                                                  input logic [3:0]        keep,
                                                  input logic              last);
    return {last, keep, hi, lo};
  endfunction

endpackage

// File: rtl/axis_tx_packer_beat_fifo.sv
// axis_beat_fifo: small show-ahead FIFO holding packed AXI beats.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless a pop frees a slot)
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry, valid whenever !empty
//   full/empty : occupancy flags from registered pointers
//   count      : number of entries held
module axis_beat_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axis_tx_packer.sv
// axis_tx_packer: packs 15-bit compressed words two per 32-bit AXI4-Stream beat.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin a frame (honoured in IDLE/DONE only)
//   c_data/c_valid  : compressed word from the compressor
//   c_end           : compressor finished (level)
//   c_stop          : stall back to the compressor
//   m_axis_*        : AXI4-Stream master (tdata/tkeep/tlast/tvalid, tready in)
//   words_cnt       : words accepted this frame (saturating)
//   beats_cnt       : beats handed off this frame (saturating)
//   done            : frame fully transmitted, held until next start
//   now_state       : current FSM state
module axis_tx_packer
  import axis_tx_packer_pkg::*;
#(
  parameter int unsigned DATA_W     = 15,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] c_data,
  input  logic              c_valid,
  input  logic              c_end,
  output logic              c_stop,
  output logic [31:0]       m_axis_tdata,
  output logic [3:0]        m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  words_cnt,
  output logic [CNT_W-1:0]  beats_cnt,
  output logic              done,
  output logic [1:0]        now_state
);

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [1:0]         pack_cnt_q, pack_cnt_d;
  logic [DATA_W-1:0]  lane0_q, lane0_d, lane1_q, lane1_d;
  logic [CNT_W-1:0]   words_q, words_d, beats_q, beats_d;

  logic               accept, pop;
  logic               push;
  logic [BEAT_W-1:0]  push_beat;
  logic [BEAT_W-1:0]  head_data;
  logic               fifo_full, fifo_empty;
  logic [FIFO_AW:0]   fifo_count;

  axis_beat_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Stall depends only on registered state so the compressor sees no
  // combinational loop through c_valid.
  assign c_stop = ((state_q == StRun) && (pack_cnt_q == 2'd2) && fifo_full) ||
                  (state_q == StFlush) || (state_q == StDrain);

  assign accept = (state_q == StRun) && c_valid && !c_stop;

  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Outputs are forced to zero while nothing is queued.
  always_comb begin
    if (fifo_empty) begin
      {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = '0;
    end else begin
      {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    pack_cnt_d = pack_cnt_q;
    lane0_d    = lane0_q;
    lane1_d    = lane1_q;
    words_d    = words_q;
    beats_d    = beats_q;
    push       = 1'b0;
    push_beat  = '0;

    if (accept && (words_q != '1)) words_d = words_q + 1'b1;
    if (pop && (beats_q != '1))    beats_d = beats_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          done_d     = 1'b0;
          pack_cnt_d = 2'd0;
          words_d    = '0;
          beats_d    = '0;
        end
      end

      StRun: begin
        if (accept) begin
          case (pack_cnt_q)
            2'd0: begin
              lane0_d    = c_data;
              pack_cnt_d = 2'd1;
            end
            2'd1: begin
              lane1_d    = c_data;
              pack_cnt_d = 2'd2;
            end
            default: begin
              // A third word proves the held pack is not the last one.
              push       = 1'b1;
              push_beat  = pack_beat(LANE_W'(lane1_q), LANE_W'(lane0_q), TKEEP_FULL, 1'b0);
              lane0_d    = c_data;
              pack_cnt_d = 2'd1;
            end
          endcase
        end
        // Never leave RUN while a valid word is still being held off.
        if (c_end && (accept || !c_valid)) state_d = StFlush;
      end

      StFlush: begin
        if (pack_cnt_q == 2'd0) begin
          state_d = StDrain;
        end else if (!fifo_full) begin
          push       = 1'b1;
          push_beat  = (pack_cnt_q == 2'd2) ?
                       pack_beat(LANE_W'(lane1_q), LANE_W'(lane0_q), TKEEP_FULL, 1'b1) :
                       pack_beat('0, LANE_W'(lane0_q), TKEEP_HALF, 1'b1);
          pack_cnt_d = 2'd0;
          state_d    = StDrain;
        end
      end

      StDrain: begin
        // Finish on the edge the last beat leaves the FIFO.
        if (fifo_empty || ((fifo_count == (FIFO_AW + 1)'(1)) && pop)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      pack_cnt_q <= 2'd0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      words_q    <= '0;
      beats_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pack_cnt_q <= pack_cnt_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
      words_q    <= words_d;
      beats_q    <= beats_d;
    end
  end

  assign words_cnt = words_q;
  assign beats_cnt = beats_q;
  assign done      = done_q;
  assign now_state = state_q;

endmodule
